// File: rtl/order_arbiter.sv
// order_arbiter: shares one registered order output between NUM_REQ strategy
// engines. It uses round-robin selection and a token-bucket issue limiter.
// A kill switch holds the block in HALT until software pulses resume.
module order_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int SYMBOL_WIDTH = 32,
   parameter int PRICE_WIDTH  = 32,
   parameter int VOLUME_WIDTH = 32,
   parameter int BURST        = 8,
   parameter int RATE_PERIOD  = 16,
   localparam int SRC_W       = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*SYMBOL_WIDTH-1:0]  req_symbol,
   input  logic [NUM_REQ*PRICE_WIDTH-1:0]   req_price,
   input  logic [NUM_REQ*VOLUME_WIDTH-1:0]  req_volume,
   input  logic [NUM_REQ-1:0]               req_side,
   input  logic [NUM_REQ*3-1:0]             req_type,
   input  logic                             kill_switch,
   input  logic                             resume,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SYMBOL_WIDTH-1:0]          out_symbol,
   output logic [PRICE_WIDTH-1:0]           out_price,
   output logic [VOLUME_WIDTH-1:0]          out_volume,
   output logic                             out_side,
   output logic [2:0]                       out_type,
   output logic [SRC_W-1:0]                 out_src,
   output logic                             halted,
   output logic [7:0]                       tokens,
   output logic [31:0]                      grant_count,
   output logic [31:0]                      throttle_count,
   output logic [15:0]                      reject_count
);

   localparam int REF_W = $clog2(RATE_PERIOD);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                    state_reg, state_next;
   logic [SRC_W-1:0]          last_grant_reg;
   logic [REF_W-1:0]          refill_cnt_reg;
   logic [7:0]                tokens_reg, tokens_next;
   logic                      out_valid_reg;
   logic [SYMBOL_WIDTH-1:0]   out_symbol_reg;
   logic [PRICE_WIDTH-1:0]    out_price_reg;
   logic [VOLUME_WIDTH-1:0]   out_volume_reg;
   logic                      out_side_reg;
   logic [2:0]                out_type_reg;
   logic [SRC_W-1:0]          out_src_reg;
   logic [31:0]               grant_count_reg, throttle_count_reg;
   logic [15:0]               reject_count_reg;

   logic [SYMBOL_WIDTH-1:0]   sym_arr  [NUM_REQ];
   logic [PRICE_WIDTH-1:0]    pri_arr  [NUM_REQ];
   logic [VOLUME_WIDTH-1:0]   vol_arr  [NUM_REQ];
   logic [2:0]                type_arr [NUM_REQ];

   logic                      win_found;
   logic [SRC_W-1:0]          win_idx;
   int                        scan_idx;
   logic                      slot_free, grant, load, refill, throttle;

   assign slot_free = !out_valid_reg || out_ready;
   assign grant     = (state_reg == RUN) && win_found && slot_free && (tokens_reg != 8'd0);
   assign load      = grant && (vol_arr[win_idx] != '0);
   assign refill    = (refill_cnt_reg == REF_W'(RATE_PERIOD - 1));
   assign throttle  = (state_reg == RUN) && (|req_valid) && slot_free && (tokens_reg == 8'd0);

   // Unpack the per-requester fields and drive the one-hot accept for the winner.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign sym_arr[gi]   = req_symbol[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      assign pri_arr[gi]   = req_price[gi*PRICE_WIDTH +: PRICE_WIDTH];
      assign vol_arr[gi]   = req_volume[gi*VOLUME_WIDTH +: VOLUME_WIDTH];
      assign type_arr[gi]  = req_type[gi*3 +: 3];
      assign req_ready[gi] = rst_n && grant && (win_idx == SRC_W'(gi));
   end

   // Round-robin scan starting just after the last granted requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(last_grant_reg) + k) % NUM_REQ;
         if (!win_found && req_valid[scan_idx[SRC_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[SRC_W-1:0];
         end
      end
   end

   // RUN/HALT next state: kill wins over resume.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (kill_switch) state_next = HALT;
         HALT:    if (resume && !kill_switch) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Token bucket: a consume and a refill in the same cycle cancel out.
   always_comb begin
      tokens_next = tokens_reg;
      if (load && !refill)
         tokens_next = tokens_reg - 8'd1;
      else if (refill && !load && (tokens_reg != 8'(BURST)))
         tokens_next = tokens_reg + 8'd1;
   end

   // Control state: FSM, round-robin pointer, refill timer and bucket.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= RUN;
         last_grant_reg <= SRC_W'(NUM_REQ - 1);
         refill_cnt_reg <= '0;
         tokens_reg     <= 8'(BURST);
      end else begin
         state_reg      <= state_next;
         if (grant) last_grant_reg <= win_idx;
         refill_cnt_reg <= refill ? '0 : refill_cnt_reg + 1'b1;
         tokens_reg     <= tokens_next;
      end
   end

   // Output order register: load on an issuing grant, clear once taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg  <= 1'b0;
         out_symbol_reg <= '0;
         out_price_reg  <= '0;
         out_volume_reg <= '0;
         out_side_reg   <= 1'b0;
         out_type_reg   <= '0;
         out_src_reg    <= '0;
      end else if (load) begin
         out_valid_reg  <= 1'b1;
         out_symbol_reg <= sym_arr[win_idx];
         out_price_reg  <= pri_arr[win_idx];
         out_volume_reg <= vol_arr[win_idx];
         out_side_reg   <= req_side[win_idx];
         out_type_reg   <= type_arr[win_idx];
         out_src_reg    <= win_idx;
      end else if (out_ready) begin
         out_valid_reg  <= 1'b0;
      end
   end

   // Statistics counters, free-running and wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count_reg    <= '0;
         throttle_count_reg <= '0;
         reject_count_reg   <= '0;
      end else begin
         if (load) grant_count_reg <= grant_count_reg + 32'd1;
         if (throttle) throttle_count_reg <= throttle_count_reg + 32'd1;
         if (grant && !load) reject_count_reg <= reject_count_reg + 16'd1;
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_symbol     = out_symbol_reg;
   assign out_price      = out_price_reg;
   assign out_volume     = out_volume_reg;
   assign out_side       = out_side_reg;
   assign out_type       = out_type_reg;
   assign out_src        = out_src_reg;
   assign halted         = (state_reg == HALT);
   assign tokens         = tokens_reg;
   assign grant_count    = grant_count_reg;
   assign throttle_count = throttle_count_reg;
   assign reject_count   = reject_count_reg;

endmodule

// File: tb/tb_order_arbiter.sv
// tb_order_arbiter: directed scenarios plus random traffic for order_arbiter.
// This bench checks the DUT against a cycle-level behavioural model.
module tb_order_arbiter;
   localparam int N = 4, W = 32, BURST = 8, RP = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0, req_side = '0, req_ready;
   logic [N*W-1:0] req_symbol = '0, req_price = '0, req_volume = '0;
   logic [N*3-1:0] req_type = '0;
   logic kill_switch = 1'b0, resume = 1'b0, out_ready = 1'b0;
   logic out_valid, out_side, halted;
   logic [W-1:0] out_symbol, out_price, out_volume;
   logic [2:0] out_type;
   logic [1:0] out_src;
   logic [7:0] tokens;
   logic [31:0] grant_count, throttle_count;
   logic [15:0] reject_count;

   int checks = 0, errors = 0;

   order_arbiter #(.NUM_REQ(N), .SYMBOL_WIDTH(W), .PRICE_WIDTH(W), .VOLUME_WIDTH(W),
                   .BURST(BURST), .RATE_PERIOD(RP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_symbol(req_symbol), .req_price(req_price), .req_volume(req_volume),
      .req_side(req_side), .req_type(req_type), .kill_switch(kill_switch),
      .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
      .out_symbol(out_symbol), .out_price(out_price), .out_volume(out_volume),
      .out_side(out_side), .out_type(out_type), .out_src(out_src), .halted(halted),
      .tokens(tokens), .grant_count(grant_count), .throttle_count(throttle_count),
      .reject_count(reject_count));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_halt, m_ov, m_side;
   int          m_tok, m_ref, m_last, m_src;
   logic [W-1:0] m_sym, m_pri, m_vol;
   logic [2:0]  m_type;
   logic [31:0] m_gc, m_tc;
   logic [15:0] m_rc;

   // Compare every cycle on the falling edge, then advance the model one cycle.
   always @(negedge clk) begin : model
      int win, idx;
      bit grant, freeslot, any, load, wrap;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] v;
      exp_rdy = '0; grant = 0; any = 0; freeslot = 0; win = -1;
      if (!rst_n) begin
         m_halt = 0; m_ov = 0; m_side = 0; m_tok = BURST; m_ref = 0; m_last = N - 1;
         m_src = 0; m_sym = '0; m_pri = '0; m_vol = '0; m_type = '0;
         m_gc = '0; m_tc = '0; m_rc = '0;
      end else begin
         any = |req_valid;
         freeslot = !m_ov || out_ready;
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
         end
         grant = !m_halt && any && freeslot && m_tok > 0;
         if (grant) exp_rdy[win] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_symbol", 64'(out_symbol), 64'(m_sym));
      chk("out_price", 64'(out_price), 64'(m_pri));
      chk("out_volume", 64'(out_volume), 64'(m_vol));
      chk("out_side", 64'(out_side), 64'(m_side));
      chk("out_type", 64'(out_type), 64'(m_type));
      chk("out_src", 64'(out_src), 64'(m_src));
      chk("halted", 64'(halted), 64'(m_halt));
      chk("tokens", 64'(tokens), 64'(m_tok));
      chk("grant_count", 64'(grant_count), 64'(m_gc));
      chk("throttle_count", 64'(throttle_count), 64'(m_tc));
      chk("reject_count", 64'(reject_count), 64'(m_rc));
      if (rst_n) begin
         load = 0;
         if (grant) begin
            m_last = win;
            v = req_volume[win*W +: W];
            if (v != 0) begin
               load = 1; m_ov = 1; m_src = win; m_gc++;
               m_sym = req_symbol[win*W +: W]; m_pri = req_price[win*W +: W];
               m_vol = v; m_side = req_side[win]; m_type = req_type[win*3 +: 3];
            end else m_rc++;
            $display("grant src=%0d vol=%0d %s", win, v, load ? "issued" : "rejected");
         end
         if (!load && out_ready) m_ov = 0;
         if (!m_halt && any && freeslot && m_tok == 0) m_tc++;
         m_ref++;
         wrap = 0;
         if (m_ref == RP) begin m_ref = 0; wrap = 1; end
         if (load) m_tok--;
         if (wrap && m_tok < BURST) m_tok++;
         if (!m_halt && kill_switch) m_halt = 1;
         else if (m_halt && resume && !kill_switch) m_halt = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      req_valid = '0; kill_switch = 0; resume = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] sym, input logic [W-1:0] pri,
                          input logic [W-1:0] vol);
      req_symbol[i*W +: W] = sym;
      req_price[i*W +: W]  = pri;
      req_volume[i*W +: W] = vol;
      req_type[i*3 +: 3]   = 3'(i + 1);
      req_side[i]          = i[0];
   endtask

   initial begin
      // Round-robin sequence and bucket exhaustion.
      hold_reset();
      for (int i = 0; i < N; i++) set_req(i, 32'h100 + i, 32'd1000 + i, 32'd10 + i);
      req_valid = '1; out_ready = 1;
      release_reset();
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); @(negedge clk); #1;
         chk("rr_src", 64'(out_src), 64'(k % N));
      end
      chk("bucket_empty", 64'(tokens), 64'd0);
      repeat (8) @(posedge clk);
      @(negedge clk); #1;
      chk("first_refill_tokens", 64'(tokens), 64'd1);
      chk("throttle_8", 64'(throttle_count), 64'd8);
      chk("refill_grant", 64'(req_ready), 64'b0001);

      // Backpressure: requester 2 alone, output held.
      hold_reset();
      set_req(2, 32'hABCD, 32'd5000, 32'd100);
      req_valid = 4'b0100; out_ready = 0;
      release_reset();
      @(negedge clk); #1 chk("accept2", 64'(req_ready), 64'b0100);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); @(negedge clk); #1;
         chk("held_valid", 64'(out_valid), 64'd1);
         chk("held_price", 64'(out_price), 64'd5000);
         chk("held_vol", 64'(out_volume), 64'd100);
         chk("held_noready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1 out_ready = 1;
      @(negedge clk); #1 chk("drain_reaccept", 64'(req_ready), 64'b0100);

      // Zero-volume reject.
      hold_reset();
      set_req(1, 32'h55, 32'd7, 32'd0);
      req_valid = 4'b0010; out_ready = 1;
      release_reset();
      @(negedge clk); #1 chk("reject_ready", 64'(req_ready), 64'b0010);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); #1;
      chk("reject_count", 64'(reject_count), 64'd1);
      chk("reject_noout", 64'(out_valid), 64'd0);
      chk("reject_tokens", 64'(tokens), 64'd8);

      // Kill switch and resume.
      hold_reset();
      for (int i = 0; i < N; i++) set_req(i, 32'h200 + i, 32'd2000 + i, 32'd5);
      req_valid = '1; out_ready = 1;
      release_reset();
      repeat (3) @(posedge clk);
      #1 kill_switch = 1;
      @(negedge clk); #1 chk("kill_cycle_grant", 64'(req_ready), 64'b1000);
      @(posedge clk); @(negedge clk); #1;
      chk("halted", 64'(halted), 64'd1);
      chk("halt_noready", 64'(req_ready), 64'd0);
      @(posedge clk); #1 resume = 1;
      @(posedge clk); #1 resume = 0; kill_switch = 0;
      @(negedge clk); #1 chk("resume_ignored", 64'(halted), 64'd1);
      @(posedge clk); #1 resume = 1;
      @(posedge clk); #1 resume = 0;
      @(negedge clk); #1;
      chk("resumed", 64'(halted), 64'd0);
      chk("resume_rr", 64'(req_ready), 64'b0001);

      // Idle saturation.
      @(posedge clk); #1 req_valid = '0;
      repeat (200) @(posedge clk);
      @(negedge clk); #1 chk("saturate", 64'(tokens), 64'd8);

      // Asynchronous reset while an order is held.
      @(posedge clk); #1 req_valid = 4'b0100; out_ready = 0;
      repeat (2) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk); #1 chk("held_before_rst", 64'(out_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk("async_clear", 64'(out_valid), 64'd0);
      req_valid = '1; out_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_tokens", 64'(tokens), 64'd8);
      chk("post_rst_first", 64'(req_ready), 64'b0001);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 299) != 0);
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++)
            set_req(i, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'd0 : W'($urandom_range(1, 1000)));
         req_type = 12'($urandom);
         req_side = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) kill_switch = ~kill_switch;
         resume = ($urandom_range(0, 5) == 0);
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
